// File: rtl/countdown_timer.sv
// Loadable down-counter: one step per CLK, one-cycle DONE at expiry, STOP pauses, LOAD reloads.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode, where expiry reloads C from the last loaded value.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             LOAD,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] C,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (LOAD) begin
      c_d = D;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = D;
`endif
      // Loading zero while running is a silent abort, not an expiry.
      if (D == CNT_ZERO) begin
        state_d = ST_IDLE;
      end
    end else if (STOP) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (START) begin
        if (c_q == CNT_ZERO) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else begin
      if (c_q == CNT_ONE) begin
        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        c_d = reload_q;
`else
        c_d     = CNT_ZERO;
        state_d = ST_IDLE;
`endif
      end else if (c_q == CNT_ZERO) begin
        // Never decrement through zero, even if RUN were somehow entered at zero.
        state_d = ST_IDLE;
      end else begin
        c_d = c_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q  <= ST_IDLE;
      c_q      <= CNT_ZERO;
      done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= CNT_ZERO;
`endif
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign C    = c_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = done_q;

  a_busy_nonzero: assert property (@(posedge CLK) disable iff (!RES) BUSY |-> (C != CNT_ZERO));
`ifndef COUNTDOWN_AUTO_RELOAD_EN
  a_done_idle: assert property (@(posedge CLK) disable iff (!RES) DONE |-> (!BUSY && C == CNT_ZERO));
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand-written corner sequences, random vs. reference model.
module tb_countdown_timer;

  localparam int W = 8;

  logic         CLK, RES, LOAD, START, STOP;
  logic [W-1:0] D;
  logic [W-1:0] C;
  logic         BUSY, DONE;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .CLK(CLK), .RES(RES), .LOAD(LOAD), .START(START), .STOP(STOP),
    .D(D), .C(C), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, want finish before 200000 ns");
    $fatal(1);
  end

  typedef struct {
    logic         load, start, stop;
    logic [W-1:0] d;
    logic [W-1:0] c;
    logic         busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic l, s, p, input int d, c, input logic b, dn);
    vec_t v;
    v.load = l; v.start = s; v.stop = p;
    v.d = d[W-1:0]; v.c = c[W-1:0]; v.busy = b; v.done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] ec, input logic eb, input logic ed);
    checks++;
    if (C !== ec || BUSY !== eb || DONE !== ed) begin
      errors++;
      $display("FAIL %s: got C=%0d BUSY=%0b DONE=%0b, want C=%0d BUSY=%0b DONE=%0b",
               name, C, BUSY, DONE, ec, eb, ed);
    end
  endtask

  task automatic drive(input logic l, s, p, input logic [W-1:0] d);
    LOAD = l; START = s; STOP = p; D = d;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: a count, a running flag and the last loaded value.
  int m_cnt, m_reload;
  bit m_run, m_done;

  task automatic model_reset;
    m_cnt = 0; m_reload = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit l, s, p, input int d);
    m_done = 0;
    if (l) begin
      m_cnt = d;
      m_reload = d;
      if (d == 0) m_run = 0;
    end else if (p) begin
      m_run = 0;
    end else if (!m_run) begin
      if (s) begin
        if (m_cnt == 0) m_done = 1;
        else m_run = 1;
      end
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_cnt = m_reload;
`else
        m_run = 0;
`endif
      end
    end
  endtask

  initial begin
    logic [W-1:0] ec;
    bit           l, s, p;
    int           d;

    RES = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    #12;
    check("reset_state", 8'd0, 1'b0, 1'b0);
    RES = 1'b1;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // One-shot, pause/resume, priority and LOAD-zero abort.
    vecs.push_back(mk(1, 0, 0,  3,  3, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  2, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10, 10, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0, 10, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  9, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  8, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  7, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  6, 1, 0));
    vecs.push_back(mk(0, 0, 1,  0,  6, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,  6, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0,  6, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  5, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  4, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  3, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  2, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  9,  9, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0,  9, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  8, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0,  7, 1, 0));
    vecs.push_back(mk(1, 0, 1, 20, 20, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 19, 1, 0));
    vecs.push_back(mk(1, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0,  2,  2, 0, 0));
    vecs.push_back(mk(0, 1, 1,  0,  2, 0, 0));
    vecs.push_back(mk(0, 1, 0,  0,  2, 1, 0));
    vecs.push_back(mk(0, 1, 0,  0,  1, 1, 0));
    vecs.push_back(mk(0, 1, 0,  0,  0, 0, 1));
    vecs.push_back(mk(0, 1, 0,  0,  0, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0,  0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].start, vecs[i].stop, vecs[i].d);
      tick();
      check($sformatf("vec%0d", i), vecs[i].c, vecs[i].busy, vecs[i].done);
    end
`else
    // Periodic mode: period 4, then period 1.
    drive(1'b1, 1'b0, 1'b0, 8'd4);
    tick();
    check("auto_load", 8'd4, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    check("auto_start", 8'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      ec = (k % 4 == 0) ? 8'd4 : 8'(4 - (k % 4));
      check($sformatf("auto_cyc%0d", k), ec, 1'b1, (k % 4 == 0));
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    check("auto_stop", 8'd4, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    check("auto_p1_start", 8'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("auto_p1_%0d", k), 8'd1, 1'b1, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    tick();
    check("auto_p1_stop", 8'd1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a run.
    drive(1'b1, 1'b0, 1'b0, 8'd5);
    tick();
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    check("arst_pre", 8'd5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0);
    #3;
    RES = 1'b0;
    #1;
    check("arst_async", 8'd0, 1'b0, 1'b0);
    #1;
    RES = 1'b1;
    tick();
    check("arst_release", 8'd0, 1'b0, 1'b0);

    // Random stimulus against the reference model.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      l = ($urandom % 8 == 0);
      p = ($urandom % 10 == 0);
      s = ($urandom % 4 == 0);
      d = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 12));
      drive(l, s, p, d[W-1:0]);
      model_edge(l, s, p, d);
      tick();
      ec = m_cnt[W-1:0];
      check($sformatf("rand%0d", i), ec, m_run, m_done);
      if ($urandom % 80 == 0) begin
        RES = 1'b0;
        #1;
        model_reset();
        check($sformatf("rand_arst%0d", i), 8'd0, 1'b0, 1'b0);
        RES = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
